ip_loop_controller: RTL and testbench

IP_LOOP_CONTROLLER -- requirements
Module: ip_loop_controller

---
 rtl/bf_pkg.sv | 20 ++
 rtl/ip_loop_stack.sv | 62 ++++++
 rtl/ip_loop_controller.sv | 163 ++++++++++++++++
 tb/tb_ip_loop_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the loop-controlled instruction pointer.
// Purpose : op encodings and the controller state type, used by the
//           controller top and its bench.
// Contents: loop_op_e    - NEXT / JMP / OPEN / CLOSE
//           loop_state_e - RUN / SKIP
package bf_pkg;

  typedef enum logic [1:0] {
    OP_NEXT  = 2'd0,
    OP_JMP   = 2'd1,
    OP_OPEN  = 2'd2,
    OP_CLOSE = 2'd3
  } loop_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } loop_state_e;

endpackage : bf_pkg

// File: rtl/ip_loop_stack.sv
// LIFO holding the addresses of open loop instructions.
// Purpose : push/pop stack with a combinationally readable top entry.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           push, pop        - stack operations (never both in one cycle)
//           push_data [W]    - address to store on push
//           top [W]          - most recently pushed address (stale when empty)
//           depth            - occupancy, 0..D
//           full, empty      - occupancy flags
module ip_loop_stack #(
  parameter int W = 16,
  parameter int D = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [$clog2(D+1)-1:0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(D + 1);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  // Storage is deliberately not reset; only the occupancy counter is.
  logic [W-1:0]  r_mem [D];
  logic [DW-1:0] r_depth;

  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  assign w_full    = (r_depth == DW'(D));
  assign w_empty   = (r_depth == '0);
  assign w_wr_idx  = AW'(r_depth);
  assign w_top_idx = AW'(r_depth - DW'(1));

  always_ff @(posedge clk) begin
    if (push && !w_full) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (push && !w_full) begin
      r_depth <= r_depth + DW'(1);
    end else if (pop && !w_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign top   = r_mem[w_top_idx];
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;

endmodule : ip_loop_stack

// File: rtl/ip_loop_controller.sv
// Instruction-pointer sequencer for a bracket-loop instruction set.
// Purpose : advances ip on each update_ip strobe, handling jumps, loop
//           entry/exit through a loop stack, and forward skipping over a
//           loop body whose entry condition is false.
// Ports   : clk, rst_n                - clock, asynchronous active-low reset
//           update_ip                 - advance strobe; gates all state changes
//           op [2]                    - NEXT/JMP/OPEN/CLOSE (used in RUN)
//           cond                      - current data cell is nonzero
//           jmp_target [W]            - JMP destination
//           instr_open, instr_close   - bracket at current ip (used in SKIP)
//           err_clr                   - clears the sticky error flags
//           ip [W]                    - current instruction pointer
//           skipping                  - high in SKIP
//           depth                     - loop-stack occupancy
//           err_overflow/err_underflow- sticky error flags
module ip_loop_controller
  import bf_pkg::*;
#(
  parameter int          i_addr_width = 16,
  parameter logic [31:0] reset_vector = 32'h0,
  parameter int          stack_depth  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                update_ip,
  input  logic [1:0]                          op,
  input  logic                                cond,
  input  logic [i_addr_width-1:0]             jmp_target,
  input  logic                                instr_open,
  input  logic                                instr_close,
  input  logic                                err_clr,
  output logic [i_addr_width-1:0]             ip,
  output logic                                skipping,
  output logic [$clog2(stack_depth+1)-1:0]    depth,
  output logic                                err_overflow,
  output logic                                err_underflow
);

  localparam int W  = i_addr_width;
  localparam int D  = stack_depth;
  localparam int DW = $clog2(D + 1);

  // ip resets one before the vector so the first NEXT fetches reset_vector.
  localparam logic [W-1:0] IP_RESET = W'(reset_vector - 32'd1);
  localparam logic [W-1:0] NEST_MAX = {W{1'b1}};

  loop_state_e   r_state;
  logic [W-1:0]  r_ip;
  logic [W-1:0]  r_nest;
  logic          r_err_ov;
  logic          r_err_un;

  loop_state_e   w_state_next;
  logic [W-1:0]  w_ip_next;
  logic [W-1:0]  w_nest_next;
  logic          w_err_ov_next;
  logic          w_err_un_next;
  logic          w_push;
  logic          w_pop;

  logic [W-1:0]  w_top;
  logic [DW-1:0] w_depth;
  logic          w_full;
  logic          w_empty;

  ip_loop_stack #(
    .W (W),
    .D (D)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_ip),
    .top       (w_top),
    .depth     (w_depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_ip     <= IP_RESET;
      r_nest   <= '0;
      r_err_ov <= 1'b0;
      r_err_un <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ip     <= w_ip_next;
      r_nest   <= w_nest_next;
      r_err_ov <= w_err_ov_next;
      r_err_un <= w_err_un_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ip_next     = r_ip;
    w_nest_next   = r_nest;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    // Clear first so that a new error raised below in the same cycle wins.
    w_err_ov_next = err_clr ? 1'b0 : r_err_ov;
    w_err_un_next = err_clr ? 1'b0 : r_err_un;

    if (update_ip) begin
      w_ip_next = r_ip + W'(1);
      case (r_state)
        ST_RUN: begin
          case (op)
            OP_NEXT: ;
            OP_JMP:  w_ip_next = jmp_target;
            OP_OPEN: begin
              if (cond) begin
                if (w_full) begin
                  w_err_ov_next = 1'b1;
                end else begin
                  w_push = 1'b1;
                end
              end else begin
                w_nest_next  = '0;
                w_state_next = ST_SKIP;
              end
            end
            OP_CLOSE: begin
              if (w_empty) begin
                w_err_un_next = 1'b1;
              end else if (cond) begin
                // Loop back to the instruction just after the matching '['.
                w_ip_next = w_top + W'(1);
              end else begin
                w_pop = 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_SKIP: begin
          if (instr_open && !instr_close) begin
            if (r_nest != NEST_MAX) begin
              w_nest_next = r_nest + W'(1);
            end
          end else if (instr_close && !instr_open) begin
            if (r_nest != '0) begin
              w_nest_next = r_nest - W'(1);
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  assign ip            = r_ip;
  assign skipping      = (r_state == ST_SKIP);
  assign depth         = w_depth;
  assign err_overflow  = r_err_ov;
  assign err_underflow = r_err_un;

endmodule : ip_loop_controller

// File: tb/tb_ip_loop_controller.sv
// Self-checking bench for ip_loop_controller (W=16, D=4, reset_vector=0).
// Each step drives one stimulus cycle and pushes the expected post-edge
// state into a scoreboard queue; after the edge the entry is popped and
// compared against the DUT outputs.
module tb_ip_loop_controller;

  localparam logic [1:0] OP_N = 2'd0;
  localparam logic [1:0] OP_J = 2'd1;
  localparam logic [1:0] OP_O = 2'd2;
  localparam logic [1:0] OP_C = 2'd3;

  typedef struct {
    string       tag;
    logic [15:0] ip;
    logic        sk;
    logic [2:0]  d;
    logic        ov;
    logic        un;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        update_ip;
  logic [1:0]  op;
  logic        cond;
  logic [15:0] jmp_target;
  logic        instr_open;
  logic        instr_close;
  logic        err_clr;
  logic [15:0] ip;
  logic        skipping;
  logic [2:0]  depth;
  logic        err_overflow;
  logic        err_underflow;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  ip_loop_controller #(
    .i_addr_width (16),
    .reset_vector (32'h0),
    .stack_depth  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .update_ip     (update_ip),
    .op            (op),
    .cond          (cond),
    .jmp_target    (jmp_target),
    .instr_open    (instr_open),
    .instr_close   (instr_close),
    .err_clr       (err_clr),
    .ip            (ip),
    .skipping      (skipping),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input exp_t e);
    check_val({e.tag, ".ip"},  32'(ip),            32'(e.ip));
    check_val({e.tag, ".sk"},  32'(skipping),      32'(e.sk));
    check_val({e.tag, ".d"},   32'(depth),         32'(e.d));
    check_val({e.tag, ".ov"},  32'(err_overflow),  32'(e.ov));
    check_val({e.tag, ".un"},  32'(err_underflow), 32'(e.un));
    $display("txn %-10s ip=%04h sk=%0d d=%0d ov=%0d un=%0d", e.tag, ip, skipping, depth,
             err_overflow, err_underflow);
  endtask

  task automatic step(input string tag, input logic [1:0] f_op, input logic f_cond,
                      input logic [15:0] f_jt, input logic f_io, input logic f_ic,
                      input logic f_clr, input logic f_upd,
                      input logic [15:0] e_ip, input logic e_sk, input logic [2:0] e_d,
                      input logic e_ov, input logic e_un);
    exp_t e;
    exp_t got_e;
    op          = f_op;
    cond        = f_cond;
    jmp_target  = f_jt;
    instr_open  = f_io;
    instr_close = f_ic;
    err_clr     = f_clr;
    update_ip   = f_upd;
    e.tag = tag; e.ip = e_ip; e.sk = e_sk; e.d = e_d; e.ov = e_ov; e.un = e_un;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    update_ip   = 1'b0;
    err_clr     = 1'b0;
    instr_open  = 1'b0;
    instr_close = 1'b0;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sbq"}, 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_state(got_e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t r;
    rst_n = 1'b0; update_ip = 1'b0; op = OP_N; cond = 1'b0; jmp_target = '0;
    instr_open = 1'b0; instr_close = 1'b0; err_clr = 1'b0;
    #12;
    r.tag = "reset"; r.ip = 16'hFFFF; r.sk = 0; r.d = 0; r.ov = 0; r.un = 0;
    check_state(r);
    @(negedge clk);
    rst_n = 1'b1;
    r.tag = "rel";
    check_state(r);

    //   tag        op    c  jt        io ic clr upd  ip        sk d  ov un
    step("nx0",     OP_N, 0, 16'h0,    0, 0, 0, 1,  16'h0000, 0, 0, 0, 0);
    step("nx1",     OP_N, 0, 16'h0,    0, 0, 0, 1,  16'h0001, 0, 0, 0, 0);
    step("nx2",     OP_N, 0, 16'h0,    0, 0, 0, 1,  16'h0002, 0, 0, 0, 0);
    step("jmp5",    OP_J, 0, 16'h5,    0, 0, 0, 1,  16'h0005, 0, 0, 0, 0);
    step("open5",   OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0006, 0, 1, 0, 0);
    step("jmp9",    OP_J, 0, 16'h9,    0, 0, 0, 1,  16'h0009, 0, 1, 0, 0);
    step("cls9c1",  OP_C, 1, 16'h0,    0, 0, 0, 1,  16'h0006, 0, 1, 0, 0);
    step("jmp9b",   OP_J, 0, 16'h9,    0, 0, 0, 1,  16'h0009, 0, 1, 0, 0);
    step("cls9c0",  OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h000A, 0, 0, 0, 0);
    step("idle",    OP_N, 0, 16'h0,    0, 0, 0, 0,  16'h000A, 0, 0, 0, 0);
    step("jmp3",    OP_J, 0, 16'h3,    0, 0, 0, 1,  16'h0003, 0, 0, 0, 0);
    step("open3c0", OP_O, 0, 16'h0,    0, 0, 0, 1,  16'h0004, 1, 0, 0, 0);
    step("sk_open", OP_J, 1, 16'h64,   1, 0, 0, 1,  16'h0005, 1, 0, 0, 0);
    step("sk_cls1", OP_C, 1, 16'h0,    0, 1, 0, 1,  16'h0006, 1, 0, 0, 0);
    step("sk_cls0", OP_N, 0, 16'h0,    0, 1, 0, 1,  16'h0007, 0, 0, 0, 0);
    step("ovf1",    OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0008, 0, 1, 0, 0);
    step("ovf2",    OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0009, 0, 2, 0, 0);
    step("ovf3",    OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h000A, 0, 3, 0, 0);
    step("ovf4",    OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h000B, 0, 4, 0, 0);
    step("ovf5",    OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h000C, 0, 4, 1, 0);
    step("ov_clr",  OP_N, 0, 16'h0,    0, 0, 1, 0,  16'h000C, 0, 4, 0, 0);
    step("pop4",    OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h000D, 0, 3, 0, 0);
    step("pop3",    OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h000E, 0, 2, 0, 0);
    step("pop2",    OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h000F, 0, 1, 0, 0);
    step("pop1",    OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h0010, 0, 0, 0, 0);
    step("jmp8",    OP_J, 0, 16'h8,    0, 0, 0, 1,  16'h0008, 0, 0, 0, 0);
    step("und",     OP_C, 1, 16'h0,    0, 0, 0, 1,  16'h0009, 0, 0, 0, 1);
    step("und_clr", OP_C, 0, 16'h0,    0, 0, 1, 1,  16'h000A, 0, 0, 0, 1);
    step("un_clr",  OP_N, 0, 16'h0,    0, 0, 1, 0,  16'h000A, 0, 0, 0, 0);
    step("jmpFFFF", OP_J, 0, 16'hFFFF, 0, 0, 0, 1,  16'hFFFF, 0, 0, 0, 0);
    step("openW",   OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0000, 0, 1, 0, 0);
    step("clsW",    OP_C, 1, 16'h0,    0, 0, 0, 1,  16'h0000, 0, 1, 0, 0);
    step("clsW0",   OP_C, 0, 16'h0,    0, 0, 0, 1,  16'h0001, 0, 0, 0, 0);
    step("open1c0", OP_O, 0, 16'h0,    0, 0, 0, 1,  16'h0002, 1, 0, 0, 0);
    step("sk_both", OP_N, 0, 16'h0,    1, 1, 0, 1,  16'h0003, 1, 0, 0, 0);
    step("sk_exit", OP_N, 0, 16'h0,    0, 1, 0, 1,  16'h0004, 0, 0, 0, 0);
    step("pushA",   OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0005, 0, 1, 0, 0);
    step("pushB",   OP_O, 1, 16'h0,    0, 0, 0, 1,  16'h0006, 0, 2, 0, 0);
    step("skipD2",  OP_O, 0, 16'h0,    0, 0, 0, 1,  16'h0007, 1, 2, 0, 0);

    // Asynchronous reset well before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    r.tag = "areset"; r.ip = 16'hFFFF; r.sk = 0; r.d = 0; r.ov = 0; r.un = 0;
    check_state(r);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", OP_N, 0, 16'h0,   0, 0, 0, 1,  16'h0000, 0, 0, 0, 0);

    if (sb_q.size() != 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ip_loop_controller
